// File: rtl/cl_manycore_pkg.sv
// Shared manycore constants for the host request scheduler: op encodings,
// default op field position and the scheduler state encoding.
package cl_manycore_pkg;

    localparam logic [7:0] ePacketOp_remote_load = 8'h00;

    localparam int op_lsb_default_lp = 96;

    typedef enum logic [1:0] {
        eRun     = 2'd0,
        eDrain   = 2'd1,
        eDrained = 2'd2
    } sched_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: one-hot grant among requesters, with the priority
// pointer moving to the slot after the winner whenever a grant is issued.
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o
);

    localparam int ptr_w_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [ptr_w_lp-1:0] ptr_q, ptr_d, winner;
    logic [width_p-1:0]  hi_mask, reqs_hi, pick;

    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        hi_mask  = '0;
        grants_o = '0;
        winner   = '0;
        for (int i = 0; i < width_p; i++) begin
            hi_mask[i] = (i >= int'(ptr_q));
        end
        reqs_hi = reqs_i & hi_mask;
        pick    = (|reqs_hi) ? reqs_hi : reqs_i;
        for (int i = width_p - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grants_o    = '0;
                grants_o[i] = 1'b1;
                winner      = ptr_w_lp'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|grants_o) begin
            ptr_d = (winner == ptr_w_lp'(width_p - 1)) ? '0 : winner + ptr_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: registered state is always written with <= so every flop samples pre-edge values.
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_host_req_scheduler.sv
// Schedules host request FIFOs onto one endpoint request channel with
// round-robin arbitration, load-response reservation and a flush sequencer.
module bsg_manycore_host_req_scheduler
    import cl_manycore_pkg::*;
#(
    parameter int num_src_p    = 2,
    parameter int fifo_width_p = 128,
    parameter int load_limit_p = 16,
    parameter int op_lsb_p     = op_lsb_default_lp
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_src_p-1:0]                    src_v_i,
    input  logic [num_src_p-1:0][fifo_width_p-1:0]  src_data_i,
    output logic [num_src_p-1:0]                    src_ready_o,
    output logic                                    req_v_o,
    output logic [fifo_width_p-1:0]                 req_data_o,
    input  logic                                    req_ready_i,
    input  logic                                    rsp_yumi_i,
    input  logic                                    flush_i,
    output logic                                    idle_o,
    output logic [$clog2(load_limit_p+1)-1:0]       loads_outstanding_o
);

    localparam int cnt_w_lp = $clog2(load_limit_p + 1);
    localparam logic [cnt_w_lp-1:0] load_limit_lp = cnt_w_lp'(load_limit_p);

    sched_state_e state_q, state_d;

    logic                    v_q, v_d;
    logic [fifo_width_p-1:0] data_q, data_d;
    logic [cnt_w_lp-1:0]     loads_q, loads_d;

    logic [num_src_p-1:0]    is_load, eligible, arb_reqs, grants;
    logic [fifo_width_p-1:0] sel_data;
    logic                    load_blocked, can_accept, grant_en;
    logic                    grant_v, granted_load, yumi_eff;

    always_comb begin
        is_load = '0;
        for (int i = 0; i < num_src_p; i++) begin
            is_load[i] = (src_data_i[i][op_lsb_p +: 8] == ePacketOp_remote_load);
        end
    end

    // The limit compare uses the registered count, so a response returning in
    // the same cycle does not open a slot until the next cycle.
    assign load_blocked = (loads_q >= load_limit_lp);
    assign eligible     = src_v_i & ~(is_load & {num_src_p{load_blocked}});
    assign can_accept   = ~v_q | req_ready_i;
    assign grant_en     = ~reset_i & (state_q == eRun) & can_accept;
    assign arb_reqs     = eligible & {num_src_p{grant_en}};

    bsg_arb_round_robin #(
        .width_p (num_src_p)
    ) u_arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (arb_reqs),
        .grants_o (grants)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < num_src_p; i++) begin
            if (grants[i]) begin
                sel_data |= src_data_i[i];
            end
        end
    end

    assign grant_v      = |grants;
    assign granted_load = |(grants & is_load);
    assign yumi_eff     = rsp_yumi_i & (loads_q != '0);

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (grant_v) begin
            v_d    = 1'b1;
            data_d = sel_data;
        end else if (req_ready_i) begin
            v_d = 1'b0;
        end

        loads_d = loads_q;
        if (granted_load && !yumi_eff) begin
            loads_d = loads_q + cnt_w_lp'(1);
        end else if (!granted_load && yumi_eff) begin
            loads_d = loads_q - cnt_w_lp'(1);
        end
    end

    // Drain completion looks at next-state values so idle follows the final
    // response by one cycle rather than two.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            eRun:     if (flush_i)                      state_d = eDrain;
            eDrain:   if (!v_d && (loads_d == '0))      state_d = eDrained;
            eDrained: if (!flush_i)                     state_d = eRun;
            default:                                    state_d = eRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eRun;
            v_q     <= 1'b0;
            loads_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            loads_q <= loads_d;
        end
    end

    // NOTE: the payload register has no reset; v_q alone qualifies its contents.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign src_ready_o         = grants;
    assign req_v_o             = v_q;
    assign req_data_o          = data_q;
    assign idle_o              = (state_q == eDrained);
    assign loads_outstanding_o = loads_q;

    yumi_underflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(rsp_yumi_i && (loads_q == '0)));

endmodule

// File: tb/tb_bsg_manycore_host_req_scheduler.sv
// Directed bench for the host request scheduler: stimulus pushes expected
// packets into a scoreboard that a negedge monitor drains on each handshake.
module tb_bsg_manycore_host_req_scheduler;
    import cl_manycore_pkg::*;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int LIM = 3;
    localparam int OPL = 8;

    localparam logic [7:0] LD_OP = ePacketOp_remote_load;
    localparam logic [7:0] ST_OP = ~ePacketOp_remote_load;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [N-1:0]        src_v_i;
    logic [N-1:0][W-1:0] src_data_i;
    logic [N-1:0]        src_ready_o;
    logic                req_v_o;
    logic [W-1:0]        req_data_o;
    logic                req_ready_i;
    logic                rsp_yumi_i;
    logic                flush_i;
    logic                idle_o;
    logic [1:0]          loads_outstanding_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] src_q [N][$];
    logic [W-1:0] exp_q [$];
    logic [N-1:0] rdy_s;

    bsg_manycore_host_req_scheduler #(
        .num_src_p    (N),
        .fifo_width_p (W),
        .load_limit_p (LIM),
        .op_lsb_p     (OPL)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .src_v_i             (src_v_i),
        .src_data_i          (src_data_i),
        .src_ready_o         (src_ready_o),
        .req_v_o             (req_v_o),
        .req_data_o          (req_data_o),
        .req_ready_i         (req_ready_i),
        .rsp_yumi_i          (rsp_yumi_i),
        .flush_i             (flush_i),
        .idle_o              (idle_o),
        .loads_outstanding_o (loads_outstanding_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] st(input logic [7:0] t);
        return {ST_OP, t};
    endfunction

    function automatic logic [W-1:0] ld(input logic [7:0] t);
        return {LD_OP, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            src_v_i[i]    = (src_q[i].size() > 0);
            src_data_i[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic put(input int s, input logic [W-1:0] pkt);
        src_q[s].push_back(pkt);
        drive_srcs();
    endtask

    task automatic expect_pkt(input logic [W-1:0] pkt);
        exp_q.push_back(pkt);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        rdy_s = src_ready_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy_s[i] && src_q[i].size() > 0) src_q[i].delete(0);
        end
        drive_srcs();
    endtask

    // Scoreboard monitor: every accepted output packet must match the next expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset_i && req_v_o === 1'b1 && req_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h want none", req_data_o);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", req_data_o, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [N-1:0] rr_exp [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    logic [N-1:0] th_rdy [12] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001,
                                  3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    logic [1:0]   th_cnt [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3};

    initial begin
        reset_i     = 1'b1;
        req_ready_i = 1'b1;
        rsp_yumi_i  = 1'b0;
        flush_i     = 1'b0;
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        settle();
        check("rst_req_v", req_v_o, 0);
        check("rst_ready", src_ready_o, 0);
        check("rst_idle", idle_o, 0);
        check("rst_loads", loads_outstanding_o, 0);
        adv();
        reset_i = 1'b0;

        // Round-robin over three store streams.
        for (int j = 0; j < 2; j++) begin
            for (int s = 0; s < N; s++) begin
                put(s, st(8'((s + 1) * 16 + j)));
                expect_pkt(st(8'((s + 1) * 16 + j)));
            end
        end
        for (int c = 0; c < 8; c++) begin
            settle();
            check($sformatf("rr_ready[%0d]", c), src_ready_o, rr_exp[c]);
            check($sformatf("rr_req_v[%0d]", c), req_v_o, (c >= 1 && c <= 6) ? 1 : 0);
            adv();
        end

        // Backpressure: held packet stays put and the pointer does not move.
        req_ready_i = 1'b0;
        put(1, st(8'h40));
        put(2, st(8'h50));
        expect_pkt(st(8'h40));
        expect_pkt(st(8'h50));
        expect_pkt(st(8'h60));
        settle();
        check("bp_first_grant", src_ready_o, 3'b010);
        adv();
        put(0, st(8'h60));
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("bp_ready[%0d]", c), src_ready_o, 0);
            check($sformatf("bp_req_v[%0d]", c), req_v_o, 1);
            check($sformatf("bp_data[%0d]", c), req_data_o, st(8'h40));
            adv();
        end
        req_ready_i = 1'b1;
        settle(); check("bp_resume_src2", src_ready_o, 3'b100); adv();
        settle(); check("bp_resume_src0", src_ready_o, 3'b001); adv();
        settle(); check("bp_quiet", src_ready_o, 0); adv();

        // Load throttle at the limit, including a response in the blocked cycle.
        for (int k = 0; k < 4; k++) begin
            put(0, ld(8'(k)));
            put(1, st(8'(8'h70 + k)));
            expect_pkt(st(8'(8'h70 + k)));
            expect_pkt(ld(8'(k)));
        end
        for (int c = 0; c < 12; c++) begin
            rsp_yumi_i = (c == 9);
            settle();
            check($sformatf("th_ready[%0d]", c), src_ready_o, th_rdy[c]);
            check($sformatf("th_loads[%0d]", c), loads_outstanding_o, th_cnt[c]);
            adv();
        end
        rsp_yumi_i = 1'b0;

        // Flush with one packet held and two loads outstanding.
        req_ready_i = 1'b0;
        rsp_yumi_i  = 1'b1;
        put(1, st(8'h80));
        expect_pkt(st(8'h80));
        settle(); check("fl_pre_grant", src_ready_o, 3'b010); adv();
        rsp_yumi_i = 1'b0;
        flush_i    = 1'b1;
        put(2, st(8'h90));
        expect_pkt(st(8'h90));
        settle();
        check("fl_f1_ready", src_ready_o, 0);
        check("fl_f1_idle", idle_o, 0);
        check("fl_f1_loads", loads_outstanding_o, 2);
        adv();
        req_ready_i = 1'b1;
        settle();
        check("fl_f2_ready", src_ready_o, 0);
        check("fl_f2_req_v", req_v_o, 1);
        adv();
        rsp_yumi_i = 1'b1;
        settle();
        check("fl_f3_ready", src_ready_o, 0);
        check("fl_f3_idle", idle_o, 0);
        adv();
        flush_i = 1'b0;
        settle();
        check("fl_f4_idle", idle_o, 0);
        check("fl_f4_loads", loads_outstanding_o, 1);
        check("fl_f4_ready", src_ready_o, 0);
        adv();
        rsp_yumi_i = 1'b0;
        settle();
        check("fl_f5_idle", idle_o, 1);
        check("fl_f5_loads", loads_outstanding_o, 0);
        check("fl_f5_ready", src_ready_o, 0);
        adv();
        settle();
        check("fl_resume_ready", src_ready_o, 3'b100);
        check("fl_resume_idle", idle_o, 0);
        adv();
        settle(); check("fl_after", src_ready_o, 0); adv();

        // Reset while a packet is held and three loads are outstanding.
        put(0, ld(8'hA0));
        put(0, ld(8'hA1));
        put(0, ld(8'hA2));
        expect_pkt(ld(8'hA0));
        expect_pkt(ld(8'hA1));
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("rm_ready[%0d]", c), src_ready_o, 3'b001);
            adv();
        end
        req_ready_i = 1'b0;
        settle();
        check("rm_held_v", req_v_o, 1);
        check("rm_held_data", req_data_o, ld(8'hA2));
        check("rm_held_loads", loads_outstanding_o, 3);
        adv();
        reset_i = 1'b1;
        settle();
        adv();
        settle();
        check("rm_req_v", req_v_o, 0);
        check("rm_loads", loads_outstanding_o, 0);
        check("rm_idle", idle_o, 0);
        check("rm_ready", src_ready_o, 0);
        adv();
        reset_i     = 1'b0;
        req_ready_i = 1'b1;
        put(0, st(8'hB0));
        put(2, st(8'hC0));
        expect_pkt(st(8'hB0));
        expect_pkt(st(8'hC0));
        settle(); check("rm_ptr_src0", src_ready_o, 3'b001); adv();
        settle(); check("rm_ptr_src2", src_ready_o, 3'b100); adv();
        settle(); check("rm_quiet", src_ready_o, 0); adv();
        settle(); adv();

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
